// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL reset/lock supervisor.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_ctrl_state_t;

  localparam int LOCK_LOSS_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; clears to 0 on rst_n.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift the async level through the flop chain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset and lock supervisor: pulses the PLL reset, waits for stable lock,
// releases the system reset, and re-resets the PLL on timeout or lock loss.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int LOCK_STABLE    = 1024,
  parameter int MAX_RETRIES    = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                             refclk,
  input  logic                             rst_n,
  input  logic                             pll_locked,
  output logic                             pll_rst,
  output logic                             sys_rst_n,
  output logic                             ready,
  output logic                             fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
  output logic [LOCK_LOSS_W-1:0]           lock_loss_cnt,
  output logic [2:0]                       state
);

  localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  logic                   locked_s;
  pll_ctrl_state_t        state_r, state_nxt_s;
  logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
  logic [RETRY_W-1:0]     retry_r, retry_nxt_s;
  logic [LOCK_LOSS_W-1:0] loss_r, loss_nxt_s;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (refclk),
    .rst_n(rst_n),
    .d    (pll_locked),
    .q    (locked_s)
  );

  // Next-state and counter logic; cnt restarts from zero on every state change
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    retry_nxt_s = retry_r;
    loss_nxt_s  = loss_r;
    case (state_r)
      RESET_PLL: begin
        if (cnt_r == CNT_W'(PLL_RST_CYCLES - 1)) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle
        if (locked_s) begin
          state_nxt_s = STABLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_W'(LOCK_TIMEOUT - 1)) begin
          cnt_nxt_s = {CNT_W{1'b0}};
          if (retry_r == RETRY_W'(MAX_RETRIES)) begin
            state_nxt_s = FAIL;
          end else begin
            state_nxt_s = RESET_PLL;
            retry_nxt_s = retry_r + RETRY_W'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_W'(LOCK_STABLE - 1)) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = {CNT_W{1'b0}};
          retry_nxt_s = {RETRY_W{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt_s = RESET_PLL;
          cnt_nxt_s   = {CNT_W{1'b0}};
          if (loss_r != {LOCK_LOSS_W{1'b1}}) begin
            loss_nxt_s = loss_r + LOCK_LOSS_W'(1);
          end else begin
            loss_nxt_s = loss_r;
          end
        end else begin
          cnt_nxt_s = {CNT_W{1'b0}};
        end
      end
      FAIL: begin
        cnt_nxt_s = {CNT_W{1'b0}};
      end
      default: begin
        state_nxt_s = RESET_PLL;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_r   <= RESET_PLL;
      cnt_r     <= {CNT_W{1'b0}};
      retry_r   <= {RETRY_W{1'b0}};
      loss_r    <= {LOCK_LOSS_W{1'b0}};
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      retry_r   <= retry_nxt_s;
      loss_r    <= loss_nxt_s;
      pll_rst   <= (state_nxt_s == RESET_PLL);
      sys_rst_n <= (state_nxt_s == RUN);
      ready     <= (state_nxt_s == RUN);
      fail      <= (state_nxt_s == FAIL);
    end
  end

  assign retry_cnt     = retry_r;
  assign lock_loss_cnt = loss_r;
  assign state         = state_r;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl: directed vector table, hand-written
// corner sequences, and random stimulus checked against a phase/countdown model.
module tb_pll_reset_ctrl;

  localparam int P = 4;
  localparam int T = 32;
  localparam int L = 8;
  localparam int R = 2;
  localparam int S = 2;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fail;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  pll_reset_ctrl #(
    .PLL_RST_CYCLES(P),
    .LOCK_TIMEOUT  (T),
    .LOCK_STABLE   (L),
    .MAX_RETRIES   (R),
    .SYNC_STAGES   (S)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .fail         (fail),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt),
    .state        (state)
  );

  always #10 refclk = ~refclk;

  // Reference model: phase plus a remaining-cycles countdown, and a delay line for the synchronizer
  localparam int PH_RESET = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RUN = 3, PH_FAIL = 4;
  int m_phase = PH_RESET;
  int m_rem   = P;
  int m_retry = 0;
  int m_loss  = 0;
  int m_hist[S];

  task automatic model_step(input logic r, input logic lk);
    int ls;
    if (!r) begin
      m_phase = PH_RESET;
      m_rem   = P;
      m_retry = 0;
      m_loss  = 0;
      for (int i = 0; i < S; i++) m_hist[i] = 0;
    end else begin
      ls = m_hist[S-1];
      for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = int'(lk);
      case (m_phase)
        PH_RESET: begin
          m_rem--;
          if (m_rem == 0) begin m_phase = PH_WAIT; m_rem = T; end
        end
        PH_WAIT: begin
          if (ls != 0) begin
            m_phase = PH_STABLE; m_rem = L;
          end else begin
            m_rem--;
            if (m_rem == 0) begin
              if (m_retry == R) m_phase = PH_FAIL;
              else begin m_retry++; m_phase = PH_RESET; m_rem = P; end
            end
          end
        end
        PH_STABLE: begin
          if (ls == 0) begin
            m_phase = PH_WAIT; m_rem = T;
          end else begin
            m_rem--;
            if (m_rem == 0) begin m_phase = PH_RUN; m_retry = 0; end
          end
        end
        PH_RUN: begin
          if (ls == 0) begin
            m_loss = (m_loss < 255) ? m_loss + 1 : 255;
            m_phase = PH_RESET; m_rem = P;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, step the model at posedge, compare just after
  task automatic tick(input logic r, input logic lk);
    logic [15:0] exp_v, act_v;
    @(negedge refclk);
    rst_n = r;
    pll_locked = lk;
    @(posedge refclk);
    model_step(r, lk);
    #1;
    exp_v = {m_phase == PH_RESET, m_phase == PH_RUN, m_phase == PH_RUN, m_phase == PH_FAIL,
             3'(m_phase), 2'(m_retry), 8'(m_loss)};
    act_v = {pll_rst, sys_rst_n, ready, fail, state, retry_cnt, lock_loss_cnt};
    check("model", {16'd0, act_v}, {16'd0, exp_v});
  endtask

  task automatic hold(input logic r, input logic lk, input int n);
    for (int i = 0; i < n; i++) tick(r, lk);
  endtask

  task automatic do_reset();
    hold(1'b0, 1'b0, 2);
  endtask

  typedef struct {
    logic       rst_n;
    logic       lk;
    int         n;
    logic       e_pll_rst;
    logic       e_sys;
    logic       e_ready;
    logic       e_fail;
    logic [2:0] e_state;
    logic [1:0] e_retry;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int pulses, high, prev;
    logic r_rand, lk_rand;
    int flip_rate;

    // Reset release and normal lock: first high sample at edge k, RUN after k+10
    vecs[0] = '{1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0};
    vecs[1] = '{1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0};
    vecs[2] = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0};
    vecs[3] = '{1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0};
    vecs[4] = '{1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0};
    vecs[5] = '{1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0};
    vecs[6] = '{1'b1, 1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0};
    vecs[7] = '{1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 2'd0};

    for (int v = 0; v < 8; v++) begin
      hold(vecs[v].rst_n, vecs[v].lk, vecs[v].n);
      check($sformatf("vec%0d_pll_rst", v), {31'd0, pll_rst},   {31'd0, vecs[v].e_pll_rst});
      check($sformatf("vec%0d_sys_rst", v), {31'd0, sys_rst_n}, {31'd0, vecs[v].e_sys});
      check($sformatf("vec%0d_ready", v),   {31'd0, ready},     {31'd0, vecs[v].e_ready});
      check($sformatf("vec%0d_fail", v),    {31'd0, fail},      {31'd0, vecs[v].e_fail});
      check($sformatf("vec%0d_state", v),   {29'd0, state},     {29'd0, vecs[v].e_state});
      check($sformatf("vec%0d_retry", v),   {30'd0, retry_cnt}, {30'd0, vecs[v].e_retry});
    end

    // Glitch in STABLE after one timeout: retry_cnt kept, release 10 edges after relock
    do_reset();
    hold(1'b1, 1'b0, 40);
    check("glitch_pre_state", {29'd0, state}, 32'd1);
    check("glitch_pre_retry", {30'd0, retry_cnt}, 32'd1);
    hold(1'b1, 1'b1, 5);
    check("glitch_stable", {29'd0, state}, 32'd2);
    hold(1'b1, 1'b0, 1);
    hold(1'b1, 1'b1, 2);
    check("glitch_back_wait", {29'd0, state}, 32'd1);
    check("glitch_retry_kept", {30'd0, retry_cnt}, 32'd1);
    hold(1'b1, 1'b1, 8);
    check("glitch_not_yet", {31'd0, sys_rst_n}, 32'd0);
    hold(1'b1, 1'b1, 1);
    check("glitch_release", {31'd0, sys_rst_n}, 32'd1);
    check("glitch_retry_clr", {30'd0, retry_cnt}, 32'd0);

    // Lock never asserts: three 4-cycle pulses, FAIL after 108 cycles
    do_reset();
    pulses = 1; high = 1; prev = 1;
    for (int i = 1; i <= 108; i++) begin
      tick(1'b1, 1'b0);
      if (pll_rst && prev == 0) pulses++;
      if (pll_rst) high++;
      prev = int'(pll_rst);
      if (i == 107) begin
        check("fail_early", {31'd0, fail}, 32'd0);
        check("fail_retry", {30'd0, retry_cnt}, 32'd2);
      end
    end
    check("fail_set", {31'd0, fail}, 32'd1);
    check("fail_pulses", pulses, 32'd3);
    check("fail_rst_cycles", high, 32'd12);
    hold(1'b1, 1'b1, 50);
    check("fail_sticky", {31'd0, fail}, 32'd1);
    check("fail_pll_rst", {31'd0, pll_rst}, 32'd0);
    check("fail_state", {29'd0, state}, 32'd4);

    // Lock loss in RUN and saturation of the loss counter
    do_reset();
    hold(1'b1, 1'b1, 20);
    check("loss_run", {29'd0, state}, 32'd3);
    hold(1'b1, 1'b0, 2);
    check("loss_still_run", {31'd0, sys_rst_n}, 32'd1);
    hold(1'b1, 1'b0, 1);
    check("loss_sys_rst", {31'd0, sys_rst_n}, 32'd0);
    check("loss_pll_rst", {31'd0, pll_rst}, 32'd1);
    check("loss_cnt1", {24'd0, lock_loss_cnt}, 32'd1);
    hold(1'b1, 1'b1, 13);
    check("loss_relock", {29'd0, state}, 32'd3);
    for (int i = 0; i < 255; i++) begin
      hold(1'b1, 1'b0, 3);
      hold(1'b1, 1'b1, 13);
    end
    check("loss_saturate", {24'd0, lock_loss_cnt}, 32'd255);

    // rst_n low mid-STABLE, then a fresh 4-cycle pll_rst pulse
    do_reset();
    hold(1'b1, 1'b0, 4);
    hold(1'b1, 1'b1, 5);
    check("midrst_stable", {29'd0, state}, 32'd2);
    hold(1'b0, 1'b1, 1);
    check("midrst_vals", {24'd0, pll_rst, sys_rst_n, ready, fail, state, retry_cnt[1]},
          {24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    hold(1'b1, 1'b1, 3);
    check("midrst_pulse", {31'd0, pll_rst}, 32'd1);
    hold(1'b1, 1'b1, 1);
    check("midrst_pulse_end", {31'd0, pll_rst}, 32'd0);
    check("midrst_wait", {29'd0, state}, 32'd1);

    // Random stimulus against the model
    lk_rand = 1'b0;
    flip_rate = 16;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) flip_rate = int'($urandom_range(4, 60));
      r_rand = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, flip_rate - 1) == 0) lk_rand = ~lk_rand;
      tick(r_rand, lk_rand);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
